// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the RISC-V immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_CSRI  = 3'd7
  } imm_fmt_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

  // funct3 values 001/101 select the shift-immediate forms
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// Combinational instruction-to-immediate decoder; XLEN selects RV32 or RV64 rules.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]             inst,
  output logic signed [XLEN-1:0]  imm,
  output imm_fmt_t                fmt,
  output logic                    illegal
);

  localparam bit IS64 = (XLEN == 64);

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic signed [XLEN-1:0] zext6(input logic [5:0] v);
    return XLEN'(v);
  endfunction

  logic [6:0] opc;
  logic [2:0] funct3;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc    = inst[6:0];
  assign funct3 = inst[14:12];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    unique case (opc)
      OP_IMM: begin
        if (is_shift(funct3)) begin
          // RV32 shift amounts are 5 bits; bit 25 set is a reserved encoding
          if (!IS64 && inst[25]) begin
            illegal = 1'b1;
          end else begin
            fmt = FMT_SHAMT;
            imm = zext6(IS64 ? inst[25:20] : {1'b0, inst[24:20]});
          end
        end else begin
          fmt = FMT_I;
          imm = sext32(imm_i);
        end
      end
      OP_IMM_32: begin
        if (!IS64) begin
          illegal = 1'b1;
        end else if (is_shift(funct3)) begin
          if (inst[25]) begin
            illegal = 1'b1;
          end else begin
            fmt = FMT_SHAMT;
            imm = zext6({1'b0, inst[24:20]});
          end
        end else begin
          fmt = FMT_I;
          imm = sext32(imm_i);
        end
      end
      LOAD, JALR: begin
        fmt = FMT_I;
        imm = sext32(imm_i);
      end
      STORE: begin
        fmt = FMT_S;
        imm = sext32(imm_s);
      end
      BRANCH: begin
        fmt = FMT_B;
        imm = sext32(imm_b);
      end
      LUI, AUIPC: begin
        fmt = FMT_U;
        imm = sext32(imm_u);
      end
      JAL: begin
        fmt = FMT_J;
        imm = sext32(imm_j);
      end
      SYSTEM: begin
        // register-form CSR ops and ECALL/EBREAK carry no immediate but are legal
        if (funct3[2]) begin
          fmt = FMT_CSRI;
          imm = zext6({1'b0, inst[19:15]});
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decode feeding a main output register plus skid entry.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [XLEN-1:0] out_imm,
  output imm_fmt_t               out_fmt,
  output logic                   out_illegal,
  output logic [TAG_W-1:0]       out_tag
);

  logic signed [XLEN-1:0] dec_imm_p0;
  imm_fmt_t               dec_fmt_p0;
  logic                   dec_ill_p0;

  logic                   main_vld_p1, skid_vld_p1;
  logic signed [XLEN-1:0] main_imm_p1, skid_imm_p1;
  imm_fmt_t               main_fmt_p1, skid_fmt_p1;
  logic                   main_ill_p1, skid_ill_p1;
  logic [TAG_W-1:0]       main_tag_p1, skid_tag_p1;

  logic accept, main_free;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .inst    (in_inst),
    .imm     (dec_imm_p0),
    .fmt     (dec_fmt_p0),
    .illegal (dec_ill_p0)
  );

  // in_ready comes straight from the skid flop, so out_ready never reaches it
  assign in_ready  = !skid_vld_p1;
  assign accept    = in_valid && in_ready;
  assign main_free = !main_vld_p1 || out_ready;

  // ---- stage p0 -> p1: main register and skid control ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
      main_imm_p1 <= '0;
      main_fmt_p1 <= FMT_NONE;
      main_ill_p1 <= 1'b0;
      main_tag_p1 <= '0;
    end else if (flush) begin
      main_vld_p1 <= 1'b0;
      skid_vld_p1 <= 1'b0;
    end else if (main_free) begin
      if (skid_vld_p1) begin
        main_vld_p1 <= 1'b1;
        main_imm_p1 <= skid_imm_p1;
        main_fmt_p1 <= skid_fmt_p1;
        main_ill_p1 <= skid_ill_p1;
        main_tag_p1 <= skid_tag_p1;
        skid_vld_p1 <= 1'b0;
      end else if (accept) begin
        main_vld_p1 <= 1'b1;
        main_imm_p1 <= dec_imm_p0;
        main_fmt_p1 <= dec_fmt_p0;
        main_ill_p1 <= dec_ill_p0;
        main_tag_p1 <= in_tag;
      end else begin
        main_vld_p1 <= 1'b0;
      end
    end else if (accept) begin
      skid_vld_p1 <= 1'b1;
    end
  end

  // skid payload is only observed behind skid_vld_p1, so it needs no reset
  always_ff @(posedge clk) begin
    if (accept && !main_free) begin
      skid_imm_p1 <= dec_imm_p0;
      skid_fmt_p1 <= dec_fmt_p0;
      skid_ill_p1 <= dec_ill_p0;
      skid_tag_p1 <= in_tag;
    end
  end

  assign out_valid   = main_vld_p1;
  assign out_imm     = main_imm_p1;
  assign out_fmt     = main_fmt_p1;
  assign out_illegal = main_ill_p1;
  assign out_tag     = main_tag_p1;

endmodule
